// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch unit memory, redirect and instruction-stream signal bundle
interface fetch_unit_if #(
    parameter int N = 32,
    parameter int A = 32
);
    logic [A-1:0] imem_addr;
    logic [N-1:0] imem_data;
    logic         stall;
    logic         redirect_valid;
    logic [A-1:0] redirect_pc;
    logic         inst_valid;
    logic         inst_ready;
    logic [N-1:0] inst;
    logic [A-1:0] inst_pc;
    logic         halted;
    logic         fault;

    modport master (
        output imem_addr,
        input  imem_data,
        input  stall,
        input  redirect_valid,
        input  redirect_pc,
        output inst_valid,
        input  inst_ready,
        output inst,
        output inst_pc,
        output halted,
        output fault
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        output stall,
        output redirect_valid,
        output redirect_pc,
        input  inst_valid,
        output inst_ready,
        input  inst,
        input  inst_pc,
        input  halted,
        input  fault
    );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch with 2-entry {pc, inst} buffer, EBREAK halt and redirect fault
module fetch_unit #(
    parameter int             N        = 32,
    parameter int             A        = 32,
    parameter logic [A-1:0]   RESET_PC = '0
) (
    input  logic       clk,
    input  logic       rst_n,
    fetch_unit_if.master bus
);
    localparam logic [1:0]   ST_RUN   = 2'd0;
    localparam logic [1:0]   ST_HALT  = 2'd1;
    localparam logic [1:0]   ST_FAULT = 2'd2;
    localparam logic [N-1:0] EBREAK   = N'(32'h0010_0073);

    logic [A-1:0] r_pc;
    logic [1:0]   r_state;
    logic [1:0]   r_count;
    logic         r_rd_ptr;
    logic [A-1:0] r_pc_q   [2];
    logic [N-1:0] r_inst_q [2];

    logic w_valid;
    logic w_pop;
    logic w_push;
    logic w_wr_ptr;

    // Write slot sits count entries past the head; when full it reuses the slot being popped.
    always_comb begin
        w_valid  = (r_count != 2'd0);
        w_pop    = w_valid && bus.inst_ready;
        w_push   = (r_state == ST_RUN) && !bus.stall && !bus.redirect_valid &&
                   ((r_count < 2'd2) || w_pop);
        w_wr_ptr = r_rd_ptr ^ r_count[0];
    end

    assign bus.imem_addr  = r_pc;
    assign bus.inst_valid = w_valid;
    assign bus.inst       = r_inst_q[r_rd_ptr];
    assign bus.inst_pc    = r_pc_q[r_rd_ptr];
    assign bus.halted     = (r_state == ST_HALT);
    assign bus.fault      = (r_state == ST_FAULT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc     <= RESET_PC;
            r_state  <= ST_RUN;
            r_count  <= 2'd0;
            r_rd_ptr <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                r_pc_q[i]   <= '0;
                r_inst_q[i] <= '0;
            end
        end else if (r_state != ST_FAULT) begin
            if (bus.redirect_valid) begin
                r_count <= 2'd0;
                if (bus.redirect_pc[1:0] == 2'b00) begin
                    r_pc    <= bus.redirect_pc;
                    r_state <= ST_RUN;
                end else begin
                    r_state <= ST_FAULT;
                end
            end else begin
                if (w_push) begin
                    r_pc_q[w_wr_ptr]   <= r_pc;
                    r_inst_q[w_wr_ptr] <= bus.imem_data;
                    r_pc               <= r_pc + A'(4);
                    if (bus.imem_data == EBREAK)
                        r_state <= ST_HALT;
                end
                if (w_pop)
                    r_rd_ptr <= ~r_rd_ptr;
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 2'd1;
                    2'b01:   r_count <= r_count - 2'd1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit
module tb_fetch_unit;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ebrk_en = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    logic [31:0] m_pc;
    int          m_st;
    logic [63:0] q[$];

    fetch_unit_if #(.N(32), .A(32)) bus ();

    fetch_unit #(.N(32), .A(32), .RESET_PC(32'h0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] addr, input logic en);
        if (en && addr == 32'h10) return EBREAK;
        return addr ^ 32'hA5A5_0000;
    endfunction

    assign bus.imem_data = memf(bus.imem_addr, ebrk_en);

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        logic [63:0] h;
        logic        pop;
        logic        push;
        #1;
        check("valid", 64'(bus.inst_valid), 64'(q.size() != 0));
        check("imem_addr", 64'(bus.imem_addr), 64'(m_pc));
        check("halted", 64'(bus.halted), 64'(m_st == 1));
        check("fault", 64'(bus.fault), 64'(m_st == 2));
        if (q.size() != 0 && bus.inst_ready) begin
            h = q[0];
            check("inst_pc", 64'(bus.inst_pc), 64'(h[63:32]));
            check("inst", 64'(bus.inst), 64'(h[31:0]));
        end
        if (m_st != 2) begin
            if (bus.redirect_valid) begin
                q.delete();
                if (bus.redirect_pc[1:0] == 2'b00) begin
                    m_pc = bus.redirect_pc;
                    m_st = 0;
                end else begin
                    m_st = 2;
                end
            end else begin
                pop  = (q.size() != 0) && bus.inst_ready;
                push = (m_st == 0) && !bus.stall && ((q.size() < 2) || pop);
                if (pop) void'(q.pop_front());
                if (push) begin
                    q.push_back({m_pc, memf(m_pc, ebrk_en)});
                    if (memf(m_pc, ebrk_en) == EBREAK) m_st = 1;
                    m_pc = m_pc + 32'd4;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_valid", 64'(bus.inst_valid), 64'd0);
        check("rst_pc", 64'(bus.imem_addr), 64'd0);
        check("rst_inst", 64'(bus.inst), 64'd0);
        check("rst_inst_pc", 64'(bus.inst_pc), 64'd0);
        check("rst_halted", 64'(bus.halted), 64'd0);
        check("rst_fault", 64'(bus.fault), 64'd0);
        @(negedge clk);
        @(negedge clk);
        check("rst_hold_valid", 64'(bus.inst_valid), 64'd0);
        rst_n = 1'b1;
        q.delete();
        m_pc = 32'h0;
        m_st = 0;
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = pc;
        step();
        bus.redirect_valid = 1'b0;
    endtask

    initial begin
        bus.stall          = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.inst_ready     = 1'b1;
        m_pc = 32'h0;
        m_st = 0;

        // streaming from reset, with a short stall burst
        do_reset();
        repeat (6) step();
        check("stream_pc5", 64'(bus.inst_pc), 64'h14);
        bus.stall = 1'b1;
        repeat (3) step();
        bus.stall = 1'b0;
        repeat (4) step();

        // backpressure from a fresh reset
        do_reset();
        bus.inst_ready = 1'b0;
        repeat (3) step();
        check("bp_pc", 64'(bus.imem_addr), 64'h8);
        check("bp_head", 64'(bus.inst_pc), 64'h0);
        bus.inst_ready = 1'b1;
        repeat (5) step();

        // reset while the buffer is full
        bus.inst_ready = 1'b0;
        repeat (3) step();
        do_reset();
        bus.inst_ready = 1'b1;
        step();

        // redirect with a full buffer
        bus.inst_ready = 1'b0;
        repeat (3) step();
        redirect_to(32'h100);
        check("rd_flush", 64'(bus.inst_valid), 64'd0);
        bus.inst_ready = 1'b1;
        step();
        check("rd_first", 64'(bus.inst_pc), 64'h100);
        step();
        check("rd_second", 64'(bus.inst_pc), 64'h104);
        repeat (2) step();

        // EBREAK halt, then redirect out of HALT
        ebrk_en = 1'b1;
        redirect_to(32'h0);
        repeat (8) step();
        check("eb_halted", 64'(bus.halted), 64'd1);
        check("eb_pc", 64'(bus.imem_addr), 64'h14);
        redirect_to(32'h40);
        check("eb_unhalt", 64'(bus.halted), 64'd0);
        step();
        check("eb_new_pc", 64'(bus.inst_pc), 64'h40);
        ebrk_en = 1'b0;
        repeat (2) step();

        // misaligned redirect locks into FAULT
        redirect_to(32'h102);
        check("mis_fault", 64'(bus.fault), 64'd1);
        check("mis_valid", 64'(bus.inst_valid), 64'd0);
        redirect_to(32'h200);
        check("mis_ignore", 64'(bus.imem_addr), 64'(m_pc));
        repeat (2) step();
        do_reset();
        step();
        check("mis_cleared", 64'(bus.fault), 64'd0);

        // pc wrap
        redirect_to(32'hFFFF_FFFC);
        step();
        check("wrap_hi", 64'(bus.inst_pc), 64'hFFFF_FFFC);
        step();
        check("wrap_lo", 64'(bus.inst_pc), 64'h0);
        repeat (2) step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter N, default 32, instruction width.
REQ-002 SHALL have parameter A, default 32, address width.
REQ-003 SHALL have parameter RESET_PC, default 0, first fetch address after reset.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port imem_addr  output  A  byte address to instruction memory; equals the internal PC register.
REQ-007 SHALL have port imem_data  input  N  combinational instruction memory read data for imem_addr, valid in the same cycle.
REQ-008 SHALL have port stall  input  1  when high, suppresses fetch pushes.
REQ-009 SHALL have port redirect_valid  input  1  branch/jump request.
REQ-010 SHALL have port redirect_pc  input  A  redirect target.
REQ-011 SHALL have port inst_valid  output  1  buffer head valid.
REQ-012 SHALL have port inst_ready  input  1  consumer accepts head.
REQ-013 SHALL have port inst  output  N  head instruction.
REQ-014 SHALL have port inst_pc  output  A  head instruction address.
REQ-015 SHALL have port halted  output  1  high in HALT state.
REQ-016 SHALL have port fault  output  1  high in FAULT state.

Function
REQ-017 SHALL implement states RUN, HALT and FAULT, plus a 2-entry FIFO of {pc, instruction} and a 2-bit occupancy count.
REQ-018 SHALL drive inst_valid = (count != 0), with inst and inst_pc taken from the FIFO head.
REQ-019 SHALL pop the head at the edge where inst_valid and inst_ready are both high.
REQ-020 SHALL push {pc, imem_data} and set pc <= pc+4 at an edge when all hold: state RUN, stall low, redirect_valid low, and (count<2 or a pop occurs that edge).
REQ-021 SHALL allow simultaneous push and pop; count is unchanged and order is preserved.
REQ-022 SHALL wrap pc+4 modulo 2^A (0xFFFFFFFC -> 0x00000000).
REQ-023 SHALL, after pushing an instruction equal to 32'h00100073 (EBREAK), enter HALT; the EBREAK is still delivered and the FIFO keeps draining.
REQ-024 SHALL perform no pushes in HALT; pc holds the address after the EBREAK.
REQ-025 SHALL give redirect_valid priority over push, pop, stall and halt: at that edge the FIFO is flushed (count <= 0) and no push occurs.
REQ-026 SHALL, on an aligned redirect (redirect_pc[1:0] == 0), set pc <= redirect_pc and state <= RUN, including from HALT.
REQ-027 SHALL, on a misaligned redirect, flush the FIFO, leave pc unchanged and enter FAULT.
REQ-028 SHALL ignore all inputs in FAULT; only rst_n exits FAULT.
REQ-029 SHALL give redirect-to-valid latency of 1 cycle: redirect at edge k, push at edge k+1, inst_valid high after edge k+1 with inst_pc = redirect_pc.
REQ-030 SHALL hold inst and inst_pc stable while inst_valid is high and inst_ready is low.

Reset
REQ-031 SHALL, while rst_n is low, asynchronously force pc = RESET_PC, count = 0, state = RUN, inst_valid = 0, halted = 0 and fault = 0, regardless of clk.
REQ-032 SHALL drive inst and inst_pc to 0 during reset.
REQ-033 SHALL perform the first push at the first rising edge after rst_n deasserts, if stall is low.
REQ-034 SHALL, on reset asserted mid-operation, discard FIFO contents immediately.

Verification
REQ-035 SHALL be verified for reset then streaming: rst_n released, stall=0, inst_ready=1, memory returns addr-derived words -> inst_pc sequence 0,4,8,... one per cycle, inst_valid continuous from cycle 1.
REQ-036 SHALL be verified for backpressure: inst_ready=0 for 3 cycles -> count reaches 2, pc stops at 8, inst_pc holds 0; on release, 0,4,8 are delivered in order with no loss or duplication.
REQ-037 SHALL be verified for redirect with a full FIFO: redirect_pc=0x100 -> FIFO flushed, inst_valid=0 for one cycle, then inst_pc=0x100, then 0x104.
REQ-038 SHALL be verified for EBREAK: memory returns 32'h00100073 at 0x10 -> that instruction is delivered, halted=1, no further pushes; redirect to 0x40 -> halted=0, inst_pc=0x40 next.
REQ-039 SHALL be verified for a misaligned redirect: redirect_pc=0x102 -> fault=1, inst_valid=0, with later redirects ignored; rst_n pulse -> fault=0, pc=RESET_PC.
REQ-040 SHALL be verified for wrap: redirect to 0xFFFFFFFC -> inst_pc 0xFFFFFFFC, then 0x00000000.
